// File: rtl/fetch_unit.sv
// fetch_unit: program-counter generation, instruction-memory req/ack
// handshake and a small PC-tagged instruction queue feeding the next
// pipeline register. Handles downstream stall and branch/jump redirect.
module fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imemReq,
    output logic [DATA_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirectPC,
    input  logic              stall,
    output logic              instrValid,
    output logic [DATA_W-1:0] instrOut,
    output logic [DATA_W-1:0] pcOut,
    output logic [DATA_W-1:0] pcPlus4Out
);

    localparam int               PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int               CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

    typedef enum logic {REQ, DISCARD} state_t;

    state_t            state, stateNext;
    logic [DATA_W-1:0] fetchPC, fetchPCNext;
    logic [DATA_W-1:0] target, targetNext;
    logic [DATA_W-1:0] redirectTarget;
    logic              reqNext;
    logic              ackIn;
    logic              doEnq, doDeq, doFlush;
    logic [CNT_W-1:0]  count, countNext;
    logic [PTR_W-1:0]  headPtr, headPtrNext;
    logic [PTR_W-1:0]  tailPtr, tailPtrNext;
    logic [DATA_W-1:0] instrQ [QDEPTH];
    logic [DATA_W-1:0] pcQ    [QDEPTH];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign imemAddr       = fetchPC;
    assign ackIn          = imemReq & imemAck;
    assign redirectTarget = redirectPC & ~DATA_W'(3);

    // State register: FSM, fetch PC, held request, queue pointers and count
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= REQ;
            fetchPC <= RESET_PC;
            target  <= RESET_PC;
            imemReq <= 1'b0;
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            state   <= stateNext;
            fetchPC <= fetchPCNext;
            target  <= targetNext;
            imemReq <= reqNext;
            count   <= countNext;
            headPtr <= headPtrNext;
            tailPtr <= tailPtrNext;
        end
    end

    // Queue storage: entries carry the instruction and the address it came from
    always_ff @(posedge CLK) begin
        if (doEnq) begin
            instrQ[tailPtr] <= imemData;
            pcQ[tailPtr]    <= fetchPC;
        end
    end

    // Next-state: redirect beats ack/dequeue; an unacked request must be held
    always_comb begin
        stateNext   = state;
        fetchPCNext = fetchPC;
        targetNext  = target;
        reqNext     = imemReq;
        doFlush     = 1'b0;
        doEnq       = 1'b0;
        doDeq       = !redirect && (count != '0) && !stall;
        countNext   = count;
        headPtrNext = headPtr;
        tailPtrNext = tailPtr;

        if (redirect) begin
            doFlush    = 1'b1;
            targetNext = redirectTarget;
            reqNext    = 1'b1;
            if (imemReq && !imemAck) begin
                stateNext = DISCARD;
            end else begin
                stateNext   = REQ;
                fetchPCNext = redirectTarget;
            end
        end else if (state == DISCARD) begin
            reqNext = 1'b1;
            if (ackIn) begin
                stateNext   = REQ;
                fetchPCNext = target;
            end
        end else begin
            doEnq = ackIn;
            if (ackIn) begin
                fetchPCNext = fetchPC + DATA_W'(4);
            end
        end

        if (doFlush) begin
            countNext   = '0;
            headPtrNext = '0;
            tailPtrNext = '0;
        end else begin
            if (doEnq) begin
                tailPtrNext = nextPtr(tailPtr);
            end
            if (doDeq) begin
                headPtrNext = nextPtr(headPtr);
            end
            case ({doEnq, doDeq})
                2'b10:   countNext = count + CNT_W'(1);
                2'b01:   countNext = count - CNT_W'(1);
                default: countNext = count;
            endcase
        end

        if (!redirect && state == REQ) begin
            reqNext = (imemReq && !imemAck) || (countNext < FULL_CNT);
        end
    end

    // Outputs: queue head, forced to zero while the queue is empty
    always_comb begin
        instrValid = (count != '0);
        instrOut   = '0;
        pcOut      = '0;
        pcPlus4Out = '0;
        if (instrValid) begin
            instrOut   = instrQ[headPtr];
            pcOut      = pcQ[headPtr];
            pcPlus4Out = pcQ[headPtr] + DATA_W'(4);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a simple latency-programmable
// instruction memory and checks delivered instructions through a scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } sbEntry_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        stall = 1'b0;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;

    sbEntry_t    sbQ[$];
    int          checks = 0;
    int          fails = 0;
    int          memLatency = 1;
    int          waitCnt = 0;
    logic [31:0] expAddr = RESET_PC;
    logic [31:0] savedTarget = RESET_PC;
    logic        discarding = 1'b0;

    fetch_unit #(
        .DATA_W  (32),
        .RESET_PC(RESET_PC),
        .QDEPTH  (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemData  (imemData),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .stall     (stall),
        .instrValid(instrValid),
        .instrOut  (instrOut),
        .pcOut     (pcOut),
        .pcPlus4Out(pcPlus4Out)
    );

    // Free-running clock
    initial forever #5 CLK = ~CLK;

    // Guard against a hung run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock cycle: memory responds, scoreboard tracks, then advance to next negedge
    task automatic cycle();
        sbEntry_t    e;
        logic [31:0] tgt;
        logic [31:0] expP4;
        if (imemReq === 1'b1 && memLatency > 0) begin
            if (waitCnt >= memLatency - 1) begin
                imemAck  = 1'b1;
                imemData = imemAddr ^ DATA_KEY;
                waitCnt  = 0;
            end else begin
                imemAck = 1'b0;
                waitCnt++;
            end
        end else begin
            imemAck = 1'b0;
            waitCnt = 0;
        end
        #1;
        if (!RST) begin
            checks++;
            if (instrValid !== (sbQ.size() != 0)) begin
                fails++;
                $display("[TB] FAIL queue_valid: got %b, expected %b", instrValid, sbQ.size() != 0);
            end
            if (instrValid === 1'b1 && !stall && !redirect && sbQ.size() != 0) begin
                e     = sbQ.pop_front();
                expP4 = e.pc + 32'd4;
                checks++;
                if (pcOut !== e.pc) begin
                    fails++;
                    $display("[TB] FAIL deliver_pc: got %h, expected %h", pcOut, e.pc);
                end
                checks++;
                if (instrOut !== e.instr) begin
                    fails++;
                    $display("[TB] FAIL deliver_instr: got %h, expected %h", instrOut, e.instr);
                end
                checks++;
                if (pcPlus4Out !== expP4) begin
                    fails++;
                    $display("[TB] FAIL deliver_pc4: got %h, expected %h", pcPlus4Out, expP4);
                end
            end
            if (imemReq === 1'b1 && imemAck) begin
                checks++;
                if (imemAddr !== expAddr) begin
                    fails++;
                    $display("[TB] FAIL fetch_addr: got %h, expected %h", imemAddr, expAddr);
                end
                if (!redirect) begin
                    if (discarding) begin
                        discarding = 1'b0;
                        expAddr    = savedTarget;
                    end else begin
                        e.instr = expAddr ^ DATA_KEY;
                        e.pc    = expAddr;
                        sbQ.push_back(e);
                        expAddr = expAddr + 32'd4;
                    end
                end
            end
            if (redirect) begin
                tgt = redirectPC & 32'hFFFF_FFFC;
                sbQ.delete();
                if (imemReq === 1'b1 && !imemAck) begin
                    discarding  = 1'b1;
                    savedTarget = tgt;
                end else begin
                    discarding = 1'b0;
                    expAddr    = tgt;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Apply one reset edge and check the cleared outputs
    task automatic doReset();
        RST      = 1'b1;
        redirect = 1'b0;
        imemAck  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got req=%b valid=%b, expected req=0 valid=0", imemReq, instrValid);
        end
        checks++;
        if (instrOut !== 32'h0 || pcOut !== 32'h0 || pcPlus4Out !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: got instr=%h pc=%h pc4=%h, expected all 0", instrOut, pcOut, pcPlus4Out);
        end
        checks++;
        if (imemAddr !== RESET_PC) begin
            fails++;
            $display("[TB] FAIL reset_addr: got %h, expected %h", imemAddr, RESET_PC);
        end
        RST = 1'b0;
        sbQ.delete();
        expAddr    = RESET_PC;
        discarding = 1'b0;
        waitCnt    = 0;
    endtask

    // Reset release latency and one-per-cycle sequential fetch
    task automatic test_reset();
        logic [31:0] expPc;
        doReset();
        memLatency = 1;
        stall      = 1'b0;
        cycle();
        checks++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL release_edge1: got valid=%b req=%b, expected valid=0 req=1", instrValid, imemReq);
        end
        cycle();
        checks++;
        if (instrValid !== 1'b1 || pcOut !== RESET_PC) begin
            fails++;
            $display("[TB] FAIL release_edge2: got valid=%b pc=%h, expected valid=1 pc=%h", instrValid, pcOut, RESET_PC);
        end
        for (int k = 1; k <= 3; k++) begin
            cycle();
            expPc = RESET_PC + 32'(4 * k);
            checks++;
            if (instrValid !== 1'b1 || pcOut !== expPc) begin
                fails++;
                $display("[TB] FAIL stream_pc: got valid=%b pc=%h, expected valid=1 pc=%h", instrValid, pcOut, expPc);
            end
        end
    endtask

    // Stall fills the queue, request drops, release drains in order without gap
    task automatic test_stall();
        doReset();
        memLatency = 1;
        stall      = 1'b0;
        repeat (4) cycle();
        stall = 1'b1;
        repeat (6) cycle();
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b1 || pcOut !== 32'h8) begin
            fails++;
            $display("[TB] FAIL stall_full: got req=%b valid=%b pc=%h, expected req=0 valid=1 pc=00000008", imemReq, instrValid, pcOut);
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (instrValid !== 1'b1 || pcOut !== 32'hC) begin
            fails++;
            $display("[TB] FAIL drain_second: got valid=%b pc=%h, expected valid=1 pc=0000000c", instrValid, pcOut);
        end
        cycle();
        checks++;
        if (instrValid !== 1'b1 || pcOut !== 32'h10) begin
            fails++;
            $display("[TB] FAIL drain_nogap: got valid=%b pc=%h, expected valid=1 pc=00000010", instrValid, pcOut);
        end
        repeat (3) cycle();
    endtask

    // Redirect with a request outstanding: hold the old address, drop its data
    task automatic test_redirect_discard();
        int i;
        doReset();
        memLatency = 3;
        stall      = 1'b0;
        i = 0;
        while (!(imemReq === 1'b1 && imemAddr === 32'h14) && i < 80) begin
            cycle();
            i++;
        end
        checks++;
        if (i >= 80) begin
            fails++;
            $display("[TB] FAIL wait_0x14: got addr=%h, expected 00000014 within 80 cycles", imemAddr);
        end
        redirect   = 1'b1;
        redirectPC = 32'h0000_1002;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h14 || instrValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL discard_hold: got req=%b addr=%h valid=%b, expected req=1 addr=00000014 valid=0", imemReq, imemAddr, instrValid);
        end
        i = 0;
        while (!(imemReq === 1'b1 && imemAddr === 32'h1000) && i < 10) begin
            cycle();
            i++;
        end
        checks++;
        if (i != 2) begin
            fails++;
            $display("[TB] FAIL discard_release: got %0d cycles to 0x1000, expected 2", i);
        end
        i = 0;
        while (instrValid !== 1'b1 && i < 10) begin
            cycle();
            i++;
        end
        checks++;
        if (pcOut !== 32'h1000) begin
            fails++;
            $display("[TB] FAIL discard_first_pc: got %h, expected 00001000", pcOut);
        end
        repeat (4) cycle();
    endtask

    // Redirect in the ack cycle: acked data never appears, new fetch next cycle
    task automatic test_redirect_ack();
        int i;
        doReset();
        memLatency = 1;
        stall      = 1'b0;
        i = 0;
        while (!(imemReq === 1'b1 && imemAddr === 32'h20) && i < 40) begin
            cycle();
            i++;
        end
        checks++;
        if (i >= 40) begin
            fails++;
            $display("[TB] FAIL wait_0x20: got addr=%h, expected 00000020 within 40 cycles", imemAddr);
        end
        redirect   = 1'b1;
        redirectPC = 32'h0000_3000;
        cycle();
        redirect = 1'b0;
        checks++;
        if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h3000) begin
            fails++;
            $display("[TB] FAIL ack_redirect: got valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00003000", instrValid, imemReq, imemAddr);
        end
        cycle();
        checks++;
        if (instrValid !== 1'b1 || pcOut !== 32'h3000) begin
            fails++;
            $display("[TB] FAIL ack_redirect_first: got valid=%b pc=%h, expected valid=1 pc=00003000", instrValid, pcOut);
        end
        repeat (3) cycle();
    endtask

    // PC wraps from the top of the address space to zero
    task automatic test_wrap();
        memLatency = 1;
        stall      = 1'b0;
        redirect   = 1'b1;
        redirectPC = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if (pcOut !== 32'hFFFF_FFFC || pcPlus4Out !== 32'h0 || imemAddr !== 32'h0 || imemReq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wrap_top: got pc=%h pc4=%h addr=%h req=%b, expected pc=fffffffc pc4=00000000 addr=00000000 req=1", pcOut, pcPlus4Out, imemAddr, imemReq);
        end
        cycle();
        checks++;
        if (pcOut !== 32'h0 || pcPlus4Out !== 32'h4) begin
            fails++;
            $display("[TB] FAIL wrap_zero: got pc=%h pc4=%h, expected pc=00000000 pc4=00000004", pcOut, pcPlus4Out);
        end
        repeat (2) cycle();
    endtask

    // Reset while discarding with stall high, then restart at the reset PC
    task automatic test_reset_mid();
        doReset();
        memLatency = 1;
        stall      = 1'b0;
        repeat (2) cycle();
        stall = 1'b1;
        repeat (4) cycle();
        checks++;
        if (imemReq !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_full: got req=%b, expected 0", imemReq);
        end
        memLatency = 1000;
        stall      = 1'b0;
        cycle();
        stall = 1'b1;
        cycle();
        redirect   = 1'b1;
        redirectPC = 32'h0000_0500;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if (imemReq !== 1'b1 || instrValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_discard: got req=%b valid=%b, expected req=1 valid=0", imemReq, instrValid);
        end
        doReset();
        memLatency = 1;
        stall      = 1'b0;
        cycle();
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== RESET_PC) begin
            fails++;
            $display("[TB] FAIL mid_restart_req: got req=%b addr=%h, expected req=1 addr=%h", imemReq, imemAddr, RESET_PC);
        end
        cycle();
        checks++;
        if (instrValid !== 1'b1 || pcOut !== RESET_PC) begin
            fails++;
            $display("[TB] FAIL mid_restart_pc: got valid=%b pc=%h, expected valid=1 pc=%h", instrValid, pcOut, RESET_PC);
        end
        repeat (3) cycle();
    endtask

    // Test sequence
    initial begin
        @(negedge CLK);
        $display("[TB] starting fetch_unit tests");
        test_reset();
        test_stall();
        test_redirect_discard();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
